// File: rtl/id_hazard_ctrl_if.sv
// Issue-control bus between the ID stage, EX and writeback, seen by id_hazard_ctrl.
// master = pipeline side that drives decode/writeback, slave = the hazard controller.
interface id_hazard_ctrl_if #(
    parameter int MAX_PENDING = 4
);
    localparam int CW = $clog2(MAX_PENDING + 1);

    logic          id_valid;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_rt_used;
    logic [4:0]    id_dst;
    logic          id_dst_en;
    logic          ex_busy;
    logic          wb_valid;
    logic [4:0]    wb_reg;
    logic          id_stall;
    logic          id_issue;
    logic          ex_bubble;
    logic [31:0]   pending;
    logic [CW-1:0] inflight;
    logic [1:0]    state;
    logic [15:0]   stall_cycles;
    logic          wb_err;

    modport master (
        output id_valid, id_rs, id_rt, id_rt_used, id_dst, id_dst_en,
               ex_busy, wb_valid, wb_reg,
        input  id_stall, id_issue, ex_bubble, pending, inflight, state,
               stall_cycles, wb_err
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rt_used, id_dst, id_dst_en,
               ex_busy, wb_valid, wb_reg,
        output id_stall, id_issue, ex_bubble, pending, inflight, state,
               stall_cycles, wb_err
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Scoreboard issue controller between ID and EX: stalls on RAW/WAW hazards,
// a full in-flight window or EX back-pressure, and tracks stall statistics.
module id_hazard_ctrl #(
    parameter int MAX_PENDING = 4,
    parameter int WB_BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    id_hazard_ctrl_if.slave bus
);
    localparam int CW = $clog2(MAX_PENDING + 1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HAZ  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_BUSY = 2'd3;

    logic [31:0]   pending_r;
    logic [CW-1:0] inflight_r;
    logic [1:0]    state_r;
    logic [15:0]   stall_cycles_r;
    logic          wb_err_r;

    logic [31:0]   wb_mask_s;
    logic [31:0]   eff_s;
    logic          raw_s;
    logic          waw_s;
    logic          full_s;
    logic          wb_hit_s;
    logic          stall_s;
    logic          issue_s;
    logic          bubble_s;
    logic          set_s;
    logic [31:0]   set_mask_s;
    logic [31:0]   clr_mask_s;
    logic [1:0]    cause_s;
    logic [CW-1:0] inflight_nxt_s;

    // Effective scoreboard: with bypass, a register retiring this cycle is already readable.
    always_comb begin
        wb_mask_s = 32'd1 << bus.wb_reg;
        if ((WB_BYPASS == 32'sd1) && bus.wb_valid) begin
            eff_s = pending_r & ~wb_mask_s & ~32'd1;
        end else begin
            eff_s = pending_r & ~32'd1;
        end
    end

    // Hazard terms and the issue decision.
    always_comb begin
        raw_s    = eff_s[bus.id_rs] | (bus.id_rt_used & eff_s[bus.id_rt]);
        waw_s    = bus.id_dst_en & eff_s[bus.id_dst];
        wb_hit_s = bus.wb_valid & pending_r[bus.wb_reg];
        // A retiring writer frees its window slot in time for a new one.
        full_s   = bus.id_dst_en & (inflight_r == CW'(MAX_PENDING)) & ~wb_hit_s;
        stall_s  = bus.id_valid & (bus.ex_busy | raw_s | waw_s | full_s);
        issue_s  = bus.id_valid & ~stall_s;
        bubble_s = ~bus.ex_busy & ~issue_s;
    end

    // Stall cause, highest priority first.
    always_comb begin
        if (!bus.id_valid) begin
            cause_s = ST_RUN;
        end else if (bus.ex_busy) begin
            cause_s = ST_BUSY;
        end else if (raw_s || waw_s) begin
            cause_s = ST_HAZ;
        end else if (full_s) begin
            cause_s = ST_FULL;
        end else begin
            cause_s = ST_RUN;
        end
    end

    // Scoreboard set/clear masks and next in-flight count.
    always_comb begin
        set_s = issue_s & bus.id_dst_en & (bus.id_dst != 5'd0);
        if (set_s) begin
            set_mask_s = 32'd1 << bus.id_dst;
        end else begin
            set_mask_s = 32'd0;
        end
        if (wb_hit_s) begin
            clr_mask_s = wb_mask_s;
        end else begin
            clr_mask_s = 32'd0;
        end
        case ({set_s, wb_hit_s})
            2'b10:   inflight_nxt_s = inflight_r + CW'(1);
            2'b01:   inflight_nxt_s = inflight_r - CW'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // State registers; set beats clear when one register retires and reissues together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_r      <= 32'd0;
            inflight_r     <= '0;
            state_r        <= ST_RUN;
            stall_cycles_r <= 16'd0;
            wb_err_r       <= 1'b0;
        end else begin
            pending_r  <= (pending_r & ~clr_mask_s) | set_mask_s;
            inflight_r <= inflight_nxt_s;
            state_r    <= cause_s;
            if (stall_s && (stall_cycles_r != 16'hFFFF)) begin
                stall_cycles_r <= stall_cycles_r + 16'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (bus.wb_valid && !wb_hit_s) begin
                wb_err_r <= 1'b1;
            end else begin
                wb_err_r <= wb_err_r;
            end
        end
    end

    assign bus.id_stall     = stall_s;
    assign bus.id_issue     = issue_s;
    assign bus.ex_bubble    = bubble_s;
    assign bus.pending      = pending_r;
    assign bus.inflight     = inflight_r;
    assign bus.state        = state_r;
    assign bus.stall_cycles = stall_cycles_r;
    assign bus.wb_err       = wb_err_r;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: expectations are queued per cycle and
// compared against the DUT just before the next rising edge.
module tb_id_hazard_ctrl;
    localparam int S_STALL  = 0;
    localparam int S_ISSUE  = 1;
    localparam int S_BUBBLE = 2;
    localparam int S_PEND   = 3;
    localparam int S_INFL   = 4;
    localparam int S_STATE  = 5;
    localparam int S_SCNT   = 6;
    localparam int S_WBERR  = 7;
    localparam int S0_STALL = 8;
    localparam int S0_ISSUE = 9;
    localparam int S0_PEND  = 10;

    typedef struct {
        int          sig;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int errors = 0;
    logic [15:0] scnt_m = 16'd0;
    exp_t sb[$];

    always #5 clk = ~clk;

    id_hazard_ctrl_if #(.MAX_PENDING(4)) ifc1 ();
    id_hazard_ctrl_if #(.MAX_PENDING(4)) ifc0 ();

    assign ifc0.id_valid   = ifc1.id_valid;
    assign ifc0.id_rs      = ifc1.id_rs;
    assign ifc0.id_rt      = ifc1.id_rt;
    assign ifc0.id_rt_used = ifc1.id_rt_used;
    assign ifc0.id_dst     = ifc1.id_dst;
    assign ifc0.id_dst_en  = ifc1.id_dst_en;
    assign ifc0.ex_busy    = ifc1.ex_busy;
    assign ifc0.wb_valid   = ifc1.wb_valid;
    assign ifc0.wb_reg     = ifc1.wb_reg;

    id_hazard_ctrl #(.MAX_PENDING(4), .WB_BYPASS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    id_hazard_ctrl #(.MAX_PENDING(4), .WB_BYPASS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_STALL:  observe = 32'(ifc1.id_stall);
            S_ISSUE:  observe = 32'(ifc1.id_issue);
            S_BUBBLE: observe = 32'(ifc1.ex_bubble);
            S_PEND:   observe = ifc1.pending;
            S_INFL:   observe = 32'(ifc1.inflight);
            S_STATE:  observe = 32'(ifc1.state);
            S_SCNT:   observe = 32'(ifc1.stall_cycles);
            S_WBERR:  observe = 32'(ifc1.wb_err);
            S0_STALL: observe = 32'(ifc0.id_stall);
            S0_ISSUE: observe = 32'(ifc0.id_issue);
            S0_PEND:  observe = ifc0.pending;
            default:  observe = 32'hxxxx_xxxx;
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            S_STALL:  sig_name = "id_stall";
            S_ISSUE:  sig_name = "id_issue";
            S_BUBBLE: sig_name = "ex_bubble";
            S_PEND:   sig_name = "pending";
            S_INFL:   sig_name = "inflight";
            S_STATE:  sig_name = "state";
            S_SCNT:   sig_name = "stall_cycles";
            S_WBERR:  sig_name = "wb_err";
            S0_STALL: sig_name = "nobypass_id_stall";
            S0_ISSUE: sig_name = "nobypass_id_issue";
            S0_PEND:  sig_name = "nobypass_pending";
            default:  sig_name = "unknown";
        endcase
    endfunction

    task automatic chk(input int sig, input logic [31:0] exp);
        exp_t e;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Combinational expectations for this cycle; a stall advances the counter model.
    task automatic comb(input logic stall, input logic issue, input logic bubble);
        chk(S_STALL, 32'(stall));
        chk(S_ISSUE, 32'(issue));
        chk(S_BUBBLE, 32'(bubble));
        if (stall && scnt_m != 16'hFFFF) scnt_m = scnt_m + 16'd1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rtu, input logic [4:0] dst, input logic en,
                       input logic busy, input logic wbv, input logic [4:0] wbr);
        ifc1.id_valid   = v;
        ifc1.id_rs      = rs;
        ifc1.id_rt      = rt;
        ifc1.id_rt_used = rtu;
        ifc1.id_dst     = dst;
        ifc1.id_dst_en  = en;
        ifc1.ex_busy    = busy;
        ifc1.wb_valid   = wbv;
        ifc1.wb_reg     = wbr;
    endtask

    // Compare every queued expectation before the edge, then move past it.
    task automatic cyc();
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = sb.pop_front();
            got = observe(e.sig);
            checks++;
            assert (got === e.exp) else begin
                errors++;
                $error("FAIL %s got=%0h exp=%0h", sig_name(e.sig), got, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        chk(S_PEND, 32'h0); chk(S_INFL, 32'd0); chk(S_STATE, 32'd0);
        chk(S_SCNT, 32'd0); chk(S_WBERR, 32'd0);
        comb(1'b0, 1'b0, 1'b1);
        cyc();
        rst_n = 1'b1;

        // add $3, then sub reading $3 with a bypassed writeback two cycles later
        drv(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0);
        comb(1'b0, 1'b1, 1'b0);
        cyc();
        drv(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        chk(S_PEND, 32'h8); chk(S_INFL, 32'd1); chk(S_STATE, 32'd0);
        comb(1'b1, 1'b0, 1'b1);
        cyc();
        chk(S_STATE, 32'd1); chk(S_SCNT, 32'(scnt_m));
        comb(1'b1, 1'b0, 1'b1);
        cyc();
        drv(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd3);
        chk(S_STATE, 32'd1); chk(S_SCNT, 32'(scnt_m)); chk(S_PEND, 32'h8);
        comb(1'b0, 1'b1, 1'b0);
        cyc();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
        chk(S_PEND, 32'h20); chk(S_INFL, 32'd1); chk(S_STATE, 32'd0);
        comb(1'b0, 1'b0, 1'b1);
        cyc();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk(S_PEND, 32'h0); chk(S_INFL, 32'd0);
        comb(1'b0, 1'b0, 1'b1);
        cyc();

        // Fill the window with $1..$4, then a fifth writer hits FULL
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 5'd0, 5'd0, 1'b0, 5'(i), 1'b1, 1'b0, 1'b0, 5'd0);
            comb(1'b0, 1'b1, 1'b0);
            cyc();
        end
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        chk(S_INFL, 32'd4); chk(S_PEND, 32'h1E);
        comb(1'b1, 1'b0, 1'b1);
        cyc();
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 5'd1);
        chk(S_STATE, 32'd2); chk(S_INFL, 32'd4);
        comb(1'b0, 1'b1, 1'b0);
        cyc();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk(S_INFL, 32'd4); chk(S_PEND, 32'h3C); chk(S_STATE, 32'd0);
        comb(1'b0, 1'b0, 1'b1);
        cyc();
        for (int i = 2; i <= 5; i++) begin
            drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'(i));
            comb(1'b0, 1'b0, 1'b1);
            cyc();
        end
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk(S_INFL, 32'd0); chk(S_PEND, 32'h0); chk(S_WBERR, 32'd0);
        comb(1'b0, 1'b0, 1'b1);
        cyc();

        // WAW on $7, released by a bypassed writeback; the reissue keeps the bit set
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0);
        comb(1'b0, 1'b1, 1'b0);
        cyc();
        chk(S_PEND, 32'h80);
        comb(1'b1, 1'b0, 1'b1);
        cyc();
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7);
        chk(S_STATE, 32'd1);
        comb(1'b0, 1'b1, 1'b0);
        cyc();
        drv(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        chk(S_PEND, 32'h80); chk(S_INFL, 32'd1);
        comb(1'b0, 1'b1, 1'b0);
        cyc();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
        chk(S_PEND, 32'h80); chk(S_INFL, 32'd1);
        comb(1'b0, 1'b0, 1'b1);
        cyc();

        // EX busy on top of a RAW hazard, held long enough to saturate the counter
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0);
        chk(S_PEND, 32'h0); chk(S_INFL, 32'd0);
        comb(1'b0, 1'b1, 1'b0);
        cyc();
        drv(1'b1, 5'd8, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0);
        chk(S_PEND, 32'h100);
        comb(1'b1, 1'b0, 1'b0);
        cyc();
        chk(S_STATE, 32'd3); chk(S_SCNT, 32'(scnt_m));
        comb(1'b1, 1'b0, 1'b0);
        cyc();
        repeat (70000) @(posedge clk);
        #1;
        scnt_m = 16'hFFFF;
        chk(S_SCNT, 32'(scnt_m)); chk(S_STATE, 32'd3);
        comb(1'b1, 1'b0, 1'b0);
        cyc();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8);
        chk(S_SCNT, 32'hFFFF);
        comb(1'b0, 1'b0, 1'b1);
        cyc();

        // Spurious writeback of $9 sets the sticky error flag
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
        chk(S_PEND, 32'h0); chk(S_WBERR, 32'd0);
        comb(1'b0, 1'b0, 1'b1);
        cyc();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk(S_WBERR, 32'd1); chk(S_PEND, 32'h0); chk(S_INFL, 32'd0);
        cyc();
        chk(S_WBERR, 32'd1);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        scnt_m = 16'd0;
        chk(S_PEND, 32'h0); chk(S_INFL, 32'd0); chk(S_STATE, 32'd0);
        chk(S_SCNT, 32'd0); chk(S_WBERR, 32'd0);
        comb(1'b0, 1'b0, 1'b1);
        cyc();

        // Reset during a stall drops the writer; its later writeback is an error
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0);
        comb(1'b0, 1'b1, 1'b0);
        cyc();
        drv(1'b1, 5'd10, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 5'd0);
        comb(1'b1, 1'b0, 1'b1);
        cyc();
        rst_n = 1'b0;
        comb(1'b1, 1'b0, 1'b1);
        cyc();
        rst_n = 1'b1;
        scnt_m = 16'd0;
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10);
        chk(S_PEND, 32'h0); chk(S_INFL, 32'd0); chk(S_STATE, 32'd0);
        chk(S_SCNT, 32'(scnt_m)); chk(S_WBERR, 32'd0);
        comb(1'b0, 1'b0, 1'b1);
        cyc();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk(S_WBERR, 32'd1);
        cyc();

        // Without bypass the reader waits one cycle past the writeback
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        drv(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0);
        chk(S0_ISSUE, 32'd1);
        cyc();
        drv(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk(S0_STALL, 32'd1);
        cyc();
        drv(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3);
        chk(S0_STALL, 32'd1); chk(S0_ISSUE, 32'd0); chk(S0_PEND, 32'h8);
        chk(S_ISSUE, 32'd1);
        cyc();
        drv(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk(S0_STALL, 32'd0); chk(S0_ISSUE, 32'd1); chk(S0_PEND, 32'h0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
